// File: rtl/vga_digit_overlay.sv
// Seven-segment digit overlay for the VGA pixel stream. It counts pixels and lines from
// the sync edges and draws N_DIGITS scaled 5x9-cell glyphs using a two-stage pipeline.
module vga_digit_overlay #(
    parameter int unsigned N_DIGITS     = 6,
    parameter int unsigned X0           = 295,
    parameter int unsigned Y0           = 235,
    parameter int unsigned SCALE        = 1,
    parameter int unsigned GAP          = 3,
    parameter int unsigned PAIR_GAP     = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    h_sinc,
    input  logic                    v_sinc,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic [2:0]              fg,
    input  logic [2:0]              bg,
    output logic                    Rout,
    output logic                    Gout,
    output logic                    Bout
);
    localparam int unsigned CW = 11;
    localparam int unsigned DW = 4 * N_DIGITS;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    function automatic int unsigned left_of(input int unsigned k);
        return X0 + SCALE * (k * (5 + GAP) + (k / 2) * PAIR_GAP);
    endfunction

    logic          r_h_q, r_v_q, r_h_arm, r_v_arm;
    logic [CW-1:0] r_hcount, r_vcount;
    logic [DW-1:0] r_sh_digits;
    logic [N_DIGITS-1:0] r_sh_mask;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    logic          r_in_box;
    logic [2:0]    r_idx, r_cx;
    logic [3:0]    r_cy;
    logic [2:0]    r_rgb;

    logic          w_h_edge, w_v_edge;
    logic          w_col_hit, w_row_hit;
    logic [2:0]    w_idx, w_cx;
    logic [3:0]    w_cy;
    logic [3:0]    w_code;
    logic          w_blink, w_mid, w_lit;
    logic [6:0]    w_segs;
    logic [2:0]    w_rgb;

    // A sync level that is already high when reset releases must fall before it can edge.
    assign w_h_edge = h_sinc & ~r_h_q & r_h_arm;
    assign w_v_edge = v_sinc & ~r_v_q & r_v_arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_q    <= 1'b0;
            r_v_q    <= 1'b0;
            r_h_arm  <= 1'b0;
            r_v_arm  <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_h_q   <= h_sinc;
            r_v_q   <= v_sinc;
            r_h_arm <= r_h_arm | ~h_sinc;
            r_v_arm <= r_v_arm | ~v_sinc;
            if (w_h_edge)
                r_hcount <= '0;
            else if (r_hcount != '1)
                r_hcount <= r_hcount + CW'(1);
            if (w_v_edge)
                r_vcount <= '0;
            else if (w_h_edge)
                r_vcount <= r_vcount + CW'(1);
        end
    end

    // Per-frame shadow copy of the digit values and the blink timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_digits <= '0;
            r_sh_mask   <= '0;
            r_fcnt      <= '0;
            r_phase     <= 1'b0;
        end else if (w_v_edge) begin
            r_sh_digits <= digits;
            r_sh_mask   <= blink_mask;
            if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt  <= r_fcnt + FW'(1);
            end
        end
    end

    // Cell boundaries are elaboration-time constants, so locating a cell is just compares.
    always_comb begin
        w_col_hit = 1'b0;
        w_row_hit = 1'b0;
        w_idx     = '0;
        w_cx      = '0;
        w_cy      = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            for (int unsigned c = 0; c < 5; c++) begin
                if (32'(r_hcount) >= left_of(k) + c * SCALE &&
                    32'(r_hcount) <  left_of(k) + (c + 1) * SCALE) begin
                    w_col_hit = 1'b1;
                    w_idx     = 3'(k);
                    w_cx      = 3'(c);
                end
            end
        end
        for (int unsigned r = 0; r < 9; r++) begin
            if (32'(r_vcount) >= Y0 + r * SCALE && 32'(r_vcount) < Y0 + (r + 1) * SCALE) begin
                w_row_hit = 1'b1;
                w_cy      = 4'(r);
            end
        end
    end

    always_comb begin
        w_code  = '0;
        w_blink = 1'b0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_code  = r_sh_digits[DW-1-4*k -: 4];
                w_blink = r_sh_mask[N_DIGITS-1-k];
            end
        end
        case (w_code)
            4'd0:    w_segs = 7'h3F;
            4'd1:    w_segs = 7'h06;
            4'd2:    w_segs = 7'h5B;
            4'd3:    w_segs = 7'h4F;
            4'd4:    w_segs = 7'h66;
            4'd5:    w_segs = 7'h6D;
            4'd6:    w_segs = 7'h7D;
            4'd7:    w_segs = 7'h07;
            4'd8:    w_segs = 7'h7F;
            4'd9:    w_segs = 7'h6F;
            default: w_segs = 7'h00;
        endcase
        w_mid = (r_cx != 3'd0) && (r_cx != 3'd4);
        case (r_cy)
            4'd0:             w_lit = w_mid && w_segs[0];
            4'd1, 4'd2, 4'd3: w_lit = (r_cx == 3'd0 && w_segs[5]) || (r_cx == 3'd4 && w_segs[1]);
            4'd4:             w_lit = w_mid && w_segs[6];
            4'd5, 4'd6, 4'd7: w_lit = (r_cx == 3'd0 && w_segs[4]) || (r_cx == 3'd4 && w_segs[2]);
            4'd8:             w_lit = w_mid && w_segs[3];
            default:          w_lit = 1'b0;
        endcase
        if (!r_in_box)
            w_rgb = 3'b000;
        else if (w_lit && !(r_phase && w_blink))
            w_rgb = fg;
        else
            w_rgb = bg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_box <= 1'b0;
            r_idx    <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_rgb    <= '0;
        end else begin
            r_in_box <= w_col_hit & w_row_hit;
            r_idx    <= w_idx;
            r_cx     <= w_cx;
            r_cy     <= w_cy;
            r_rgb    <= w_rgb;
        end
    end

    assign Rout = r_rgb[2];
    assign Gout = r_rgb[1];
    assign Bout = r_rgb[0];
endmodule

// File: tb/tb_vga_digit_overlay.sv
// Bench for vga_digit_overlay: two instances (SCALE 1 and 2) share one sync stream and are
// checked every cycle against a pixel-arithmetic model plus a table of hand-computed pixels.
module tb_vga_digit_overlay;
    localparam int X0 = 20;
    localparam int Y0 = 4;
    localparam int LINE = 128;
    localparam int NLINES = 24;
    localparam int BF = 2;
    localparam int NL = 23;

    logic clk = 1'b0;
    logic rst, h_sinc, v_sinc;
    logic [23:0] digits;
    logic [5:0]  blink_mask;
    logic [2:0]  fg, bg;
    logic r0, g0, b0, r1, g1, b1;
    wire  [2:0] rgb [2];
    assign rgb[0] = {r0, g0, b0};
    assign rgb[1] = {r1, g1, b1};

    always #5 clk = ~clk;

    vga_digit_overlay #(.N_DIGITS(6), .X0(X0), .Y0(Y0), .SCALE(1), .GAP(3), .PAIR_GAP(2),
                        .BLINK_FRAMES(BF)) dut_s1 (
        .clk(clk), .rst(rst), .h_sinc(h_sinc), .v_sinc(v_sinc), .digits(digits),
        .blink_mask(blink_mask), .fg(fg), .bg(bg), .Rout(r0), .Gout(g0), .Bout(b0));

    vga_digit_overlay #(.N_DIGITS(6), .X0(X0), .Y0(Y0), .SCALE(2), .GAP(3), .PAIR_GAP(2),
                        .BLINK_FRAMES(BF)) dut_s2 (
        .clk(clk), .rst(rst), .h_sinc(h_sinc), .v_sinc(v_sinc), .digits(digits),
        .blink_mask(blink_mask), .fg(fg), .bg(bg), .Rout(r1), .Gout(g1), .Bout(b1));

    // Hand-computed pixels: instance, frame number, x, y, colour.
    int         lt_m [NL] = '{0,0,0,0,0, 0,0,0, 0,0,1,1,1,1,1,1,1, 0,0,0, 0,1, 0};
    int         lt_f [NL] = '{1,1,1,1,1, 2,2,2, 3,3,3,3,3,3,3,3,3, 4,4,4, 5,5, 6};
    int         lt_x [NL] = '{21,24,29,26,20, 30,21,65, 30,22,55,56,30,35,20,38,37, 22,29,28, 22,24, 22};
    int         lt_y [NL] = '{4,5,4,4,4, 8,4,4, 8,8,4,4,4,4,5,5,5, 8,4,5, 8,12, 8};
    logic [2:0] lt_e [NL] = '{3'd2,3'd7,3'd7,3'd0,3'd2, 3'd2,3'd2,3'd7, 3'd7,3'd2,3'd0,3'd2,3'd0,
                              3'd0,3'd2,3'd7,3'd2, 3'd7,3'd2,3'd2, 3'd7,3'd7, 3'd2};
    bit         lt_hit [NL];

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0, rst_chk = 1'b0, rst_chk_done = 1'b0, final_req = 1'b0;

    // Model state: counters, shadows and blink follow the described frame rules directly.
    int hc, vc, fcnt, vedges = 0;
    bit hq, vq, harm, varm, ph, he, ve;
    logic [23:0] sh_d;
    logic [5:0]  sh_m;
    bit s1_v [2], s1_in [2];
    int s1_x [2], s1_y [2], s1_f [2], s1_k [2], s1_cx [2], s1_cy [2];
    logic [2:0] ex [2];
    bit ex_v [2];
    int ex_x [2], ex_y [2], ex_f [2];

    function automatic byte seg_at(int cx, int cy);
        if (cy == 0 || cy == 4 || cy == 8) begin
            if (cx >= 1 && cx <= 3) return (cy == 0) ? "a" : (cy == 4) ? "g" : "d";
            return " ";
        end
        if (cx == 0) return (cy < 4) ? "f" : "e";
        if (cx == 4) return (cy < 4) ? "b" : "c";
        return " ";
    endfunction

    function automatic bit seg_lit(int code, int cx, int cy);
        string s;
        byte ch;
        ch = seg_at(cx, cy);
        case (code)
            0: s = "abcdef";   1: s = "bc";     2: s = "abdeg";  3: s = "abcdg";
            4: s = "bcfg";     5: s = "acdfg";  6: s = "acdefg"; 7: s = "abc";
            8: s = "abcdefg";  9: s = "abcdfg";
            default: s = "";
        endcase
        for (int i = 0; i < s.len(); i++)
            if (s[i] == ch) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hc = 0; vc = 0; fcnt = 0; ph = 0; hq = 0; vq = 0; harm = 0; varm = 0;
            sh_d = '0; sh_m = '0;
            for (int m = 0; m < 2; m++) begin
                s1_v[m] = 0; ex_v[m] = 0; ex[m] = 3'b000;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                ex_v[m] = s1_v[m]; ex_x[m] = s1_x[m]; ex_y[m] = s1_y[m]; ex_f[m] = s1_f[m];
                if (s1_v[m] && s1_in[m]) begin
                    int code;
                    code = int'(sh_d[4*(5-s1_k[m]) +: 4]);
                    if (seg_lit(code, s1_cx[m], s1_cy[m]) && !(ph && sh_m[5-s1_k[m]]))
                        ex[m] = fg;
                    else
                        ex[m] = bg;
                end else begin
                    ex[m] = 3'b000;
                end
            end
            for (int m = 0; m < 2; m++) begin
                int sc;
                sc = m + 1;
                s1_v[m] = 1; s1_in[m] = 0; s1_x[m] = hc; s1_y[m] = vc; s1_f[m] = vedges;
                for (int k = 0; k < 6; k++) begin
                    int left;
                    left = X0 + sc * (k * 8 + (k / 2) * 2);
                    if (hc >= left && hc < left + 5 * sc && vc >= Y0 && vc < Y0 + 9 * sc) begin
                        s1_in[m] = 1; s1_k[m] = k;
                        s1_cx[m] = (hc - left) / sc; s1_cy[m] = (vc - Y0) / sc;
                    end
                end
            end
            he = h_sinc && !hq && harm;
            ve = v_sinc && !vq && varm;
            harm = harm || !h_sinc; varm = varm || !v_sinc;
            hq = h_sinc; vq = v_sinc;
            if (ve) begin
                vedges++;
                sh_d = digits; sh_m = blink_mask;
                if (fcnt == BF - 1) begin fcnt = 0; ph = !ph; end
                else fcnt++;
            end
            if (he) hc = 0;
            else if (hc < 2047) hc++;
            if (ve) vc = 0;
            else if (he) vc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (rgb[m] !== ex[m]) begin
                    n_fail++;
                    $display("FAIL pixel dut%0d frame=%0d x=%0d y=%0d got=%b expected=%b",
                             m, ex_f[m], ex_x[m], ex_y[m], rgb[m], ex[m]);
                end
                if (ex_v[m]) begin
                    for (int i = 0; i < NL; i++) begin
                        if (lt_m[i] == m && lt_f[i] == ex_f[m] && lt_x[i] == ex_x[m] &&
                            lt_y[i] == ex_y[m]) begin
                            lt_hit[i] = 1'b1;
                            n_checks++;
                            if (rgb[m] !== lt_e[i]) begin
                                n_fail++;
                                $display("FAIL literal%0d dut%0d frame=%0d x=%0d y=%0d got=%b expected=%b",
                                         i, m, lt_f[i], lt_x[i], lt_y[i], rgb[m], lt_e[i]);
                            end
                        end
                    end
                end
            end
            if (rst_chk && !rst_chk_done) begin
                rst_chk_done = 1'b1;
                for (int m = 0; m < 2; m++) begin
                    n_checks++;
                    if (rgb[m] !== 3'b000) begin
                        n_fail++;
                        $display("FAIL reset_clears_rgb dut%0d got=%b expected=000", m, rgb[m]);
                    end
                end
            end
            if (final_req) begin
                for (int i = 0; i < NL; i++) begin
                    n_checks++;
                    if (!lt_hit[i]) begin
                        n_fail++;
                        $display("FAIL literal%0d_reached got=0 expected=1", i);
                    end
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    task automatic line(input bit with_v);
        h_sinc = 1'b1;
        v_sinc = with_v;
        repeat (2) @(negedge clk);
        h_sinc = 1'b0;
        v_sinc = 1'b0;
        repeat (LINE - 2) @(negedge clk);
    endtask

    task automatic frame(input int chg_line, input logic [23:0] chg_val, input int nlines);
        for (int l = 0; l < nlines; l++) begin
            if (l == chg_line) digits = chg_val;
            line(l == 0);
        end
    endtask

    initial begin
        rst = 1'b1; h_sinc = 1'b0; v_sinc = 1'b0;
        digits = '0; blink_mask = '0; fg = 3'b111; bg = 3'b010;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        digits = 24'h123456;
        blink_mask = 6'b100000;
        repeat (10) @(negedge clk);
        frame(-1, 24'h0, NLINES);
        digits = 24'h000000;
        frame(Y0 + 4, 24'h888888, NLINES);
        frame(-1, 24'h0, NLINES);
        digits = 24'h8F8888;
        frame(-1, 24'h0, 10);
        // Reset lands inside the glyph row with both syncs held high across release.
        h_sinc = 1'b1;
        repeat (2) @(negedge clk);
        h_sinc = 1'b0;
        repeat (22) @(negedge clk);
        rst = 1'b1; h_sinc = 1'b1; v_sinc = 1'b1;
        @(posedge clk);
        rst_chk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        h_sinc = 1'b0; v_sinc = 1'b0;
        repeat (40) @(negedge clk);
        frame(-1, 24'h0, NLINES);
        frame(-1, 24'h0, NLINES);
        repeat (10) @(negedge clk);
        final_req = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL end_of_test_not_reached");
        $fatal(1, "bench did not finish");
    end
endmodule
